vga_mem_arbiter: RTL and testbench

//  Shares the single-port frame-buffer/data memory between the VGA address generator (display fetch) and the
//  CPU load/store port. VGA has fixed priority to meet pixel deadlines; a starvation counter guarantees the
//  CPU one slot after STARVE_LIMIT consecutive denials. Memory is synchronous-read, 1-cycle latency.

---
 rtl/vga_mem_arbiter_pkg.sv | 18 +
 rtl/arb_starve_ctr.sv | 36 +++
 rtl/vga_mem_arbiter.sv | 117 +++++++++++
 tb/tb_vga_mem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mem_arbiter_pkg.sv
// Purpose: shared types and defaults for the VGA/CPU memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_mem_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH   = 16;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int STARVE_CNT_W     = 3;

    // Who owns the read data coming back from memory in the next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CPU  = 2'd2
    } resp_owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Purpose: saturating count of consecutive cycles a CPU request was denied.
// Latency: count updates on the edge after inc/clr; limit_hit is combinational from the count.
// Backpressure: none; clr has priority over inc, and the count saturates at LIMIT.
//
// Ports: clk, reset (async active-low), inc, clr, cnt (current count), limit_hit (cnt == LIMIT).
module arb_starve_ctr
    import vga_mem_arbiter_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inc,
    input  logic                    clr,
    output logic [STARVE_CNT_W-1:0] cnt,
    output logic                    limit_hit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != LIMIT_V)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt       = cnt_q;
    assign limit_hit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/vga_mem_arbiter.sv
// Purpose: shares one synchronous-read memory between VGA fetch (fixed priority) and CPU load/store.
// Latency: grant and memory drive are combinational in the accept cycle; read data/rvalid one cycle later.
// Backpressure: a loser simply sees ready low and holds its request; CPU is forced through after
//               STARVE_LIMIT consecutive denials, costing VGA one cycle.
//
// Ports: clk, reset (async active-low); vga_req/vga_addr/vga_ready/vga_rdata/vga_rvalid;
//        cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_ready/cpu_rdata/cpu_rvalid;
//        mem_addr/mem_we/mem_wdata/mem_rdata; starve_cnt (debug).
module vga_mem_arbiter
    import vga_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    vga_req,
    input  logic [ADDR_WIDTH-1:0]   vga_addr,
    output logic                    vga_ready,
    output logic [DATA_WIDTH-1:0]   vga_rdata,
    output logic                    vga_rvalid,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic                    cpu_ready,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_rvalid,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [STARVE_CNT_W-1:0] starve_cnt
);

    logic                  limit_hit;
    logic                  gnt_vga;
    logic                  gnt_cpu;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] vga_rdata_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    resp_owner_t           owner_q;
    resp_owner_t           owner_nxt;

    arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (cpu_req & ~gnt_cpu),
        .clr      (gnt_cpu | ~cpu_req),
        .cnt      (starve_cnt),
        .limit_hit(limit_hit)
    );

    // Grants are gated by reset directly so nothing is accepted while reset is held,
    // yet the very first cycle after release can grant.
    always_comb begin
        gnt_vga = 1'b0;
        gnt_cpu = 1'b0;
        if (reset) begin
            if (cpu_req && limit_hit) begin
                gnt_cpu = 1'b1;
            end else if (vga_req) begin
                gnt_vga = 1'b1;
            end else if (cpu_req) begin
                gnt_cpu = 1'b1;
            end
        end
    end

    assign vga_ready = gnt_vga;
    assign cpu_ready = gnt_cpu;

    // Address holds its last granted value in idle cycles to avoid needless toggling.
    assign mem_addr  = gnt_vga ? vga_addr : (gnt_cpu ? cpu_addr : mem_addr_q);
    assign mem_we    = gnt_cpu & cpu_we;
    assign mem_wdata = gnt_cpu ? cpu_wdata : '0;

    always_comb begin
        owner_nxt = OWN_NONE;
        if (gnt_vga) begin
            owner_nxt = OWN_VGA;
        end else if (gnt_cpu && !cpu_we) begin
            owner_nxt = OWN_CPU;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q     <= OWN_NONE;
            mem_addr_q  <= '0;
            vga_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            owner_q <= owner_nxt;
            if (gnt_vga || gnt_cpu) begin
                mem_addr_q <= mem_addr;
            end
            if (owner_q == OWN_VGA) begin
                vga_rdata_q <= mem_rdata;
            end
            if (owner_q == OWN_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    // Memory data arrives in the response cycle, so it is forwarded straight through
    // then and the captured copy is shown afterwards.
    assign vga_rvalid = (owner_q == OWN_VGA);
    assign cpu_rvalid = (owner_q == OWN_CPU);
    assign vga_rdata  = vga_rvalid ? mem_rdata : vga_rdata_q;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
module tb_vga_mem_arbiter;

    localparam bit T = 1'b1;
    localparam bit F = 1'b0;
    localparam int NV = 25;

    logic        clk;
    logic        reset;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_ready;
    logic [15:0] vga_rdata;
    logic        vga_rvalid;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [2:0]  starve_cnt;

    logic [15:0] mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    vga_mem_arbiter #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (16),
        .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_ready (vga_ready),
        .vga_rdata (vga_rdata),
        .vga_rvalid(vga_rvalid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .starve_cnt(starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read single-port memory, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        vreq;
        logic [15:0] vaddr;
        logic        creq;
        logic        cwe;
        logic [15:0] caddr;
        logic [15:0] cwdata;
        logic        e_vrdy;
        logic        e_crdy;
        logic        e_we;
        logic [15:0] e_maddr;
        logic        e_vrv;
        logic [15:0] e_vrd;
        logic        e_crv;
        logic [15:0] e_crd;
        logic [2:0]  e_st;
    } vec_t;

    vec_t vt [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0;
        mem[16'h3000] = 16'hABCD;
        mem[16'h3001] = 16'h1111;
        mem[16'h3002] = 16'h3333;
        mem[16'h0020] = 16'h2222;
        mem[16'h0021] = 16'h4444;
        mem_rdata = 16'h0;

        //        vreq vaddr     creq cwe caddr     cwdata     vrdy crdy we  maddr     vrv vrdata     crv crdata     starve
        // reset release, both requesting: VGA first
        vt[0]  = '{T, 16'h3000, T, F, 16'h0020, 16'h0000, T, F, F, 16'h3000, F, 16'h0000, F, 16'h0000, 3'd0};
        vt[1]  = '{F, 16'h3000, T, F, 16'h0020, 16'h0000, F, T, F, 16'h0020, T, 16'hABCD, F, 16'h0000, 3'd1};
        vt[2]  = '{F, 16'h3000, F, F, 16'h0020, 16'h0000, F, F, F, 16'h0020, F, 16'hABCD, T, 16'h2222, 3'd0};
        // CPU write then readback
        vt[3]  = '{F, 16'h3000, T, T, 16'h0010, 16'h1234, F, T, T, 16'h0010, F, 16'hABCD, F, 16'h2222, 3'd0};
        vt[4]  = '{F, 16'h3000, T, F, 16'h0010, 16'h0000, F, T, F, 16'h0010, F, 16'hABCD, F, 16'h2222, 3'd0};
        vt[5]  = '{F, 16'h3000, F, F, 16'h0010, 16'h0000, F, F, F, 16'h0010, F, 16'hABCD, T, 16'h1234, 3'd0};
        // alternating VGA / CPU reads
        vt[6]  = '{T, 16'h3001, F, F, 16'h0021, 16'h0000, T, F, F, 16'h3001, F, 16'hABCD, F, 16'h1234, 3'd0};
        vt[7]  = '{F, 16'h3001, T, F, 16'h0021, 16'h0000, F, T, F, 16'h0021, T, 16'h1111, F, 16'h1234, 3'd0};
        vt[8]  = '{T, 16'h3002, F, F, 16'h0021, 16'h0000, T, F, F, 16'h3002, F, 16'h1111, T, 16'h4444, 3'd0};
        vt[9]  = '{F, 16'h3002, T, F, 16'h0020, 16'h0000, F, T, F, 16'h0020, T, 16'h3333, F, 16'h4444, 3'd0};
        vt[10] = '{F, 16'h3002, F, F, 16'h0020, 16'h0000, F, F, F, 16'h0020, F, 16'h3333, T, 16'h2222, 3'd0};
        // both requesting continuously: 4 VGA then 1 forced CPU, twice
        vt[11] = '{T, 16'h3000, T, F, 16'h0021, 16'h0000, T, F, F, 16'h3000, F, 16'h3333, F, 16'h2222, 3'd0};
        vt[12] = '{T, 16'h3000, T, F, 16'h0021, 16'h0000, T, F, F, 16'h3000, T, 16'hABCD, F, 16'h2222, 3'd1};
        vt[13] = '{T, 16'h3000, T, F, 16'h0021, 16'h0000, T, F, F, 16'h3000, T, 16'hABCD, F, 16'h2222, 3'd2};
        vt[14] = '{T, 16'h3000, T, F, 16'h0021, 16'h0000, T, F, F, 16'h3000, T, 16'hABCD, F, 16'h2222, 3'd3};
        vt[15] = '{T, 16'h3000, T, F, 16'h0021, 16'h0000, F, T, F, 16'h0021, T, 16'hABCD, F, 16'h2222, 3'd4};
        vt[16] = '{T, 16'h3000, T, F, 16'h0021, 16'h0000, T, F, F, 16'h3000, F, 16'hABCD, T, 16'h4444, 3'd0};
        vt[17] = '{T, 16'h3000, T, F, 16'h0021, 16'h0000, T, F, F, 16'h3000, T, 16'hABCD, F, 16'h4444, 3'd1};
        vt[18] = '{T, 16'h3000, T, F, 16'h0021, 16'h0000, T, F, F, 16'h3000, T, 16'hABCD, F, 16'h4444, 3'd2};
        vt[19] = '{T, 16'h3000, T, F, 16'h0021, 16'h0000, T, F, F, 16'h3000, T, 16'hABCD, F, 16'h4444, 3'd3};
        vt[20] = '{T, 16'h3000, T, F, 16'h0021, 16'h0000, F, T, F, 16'h0021, T, 16'hABCD, F, 16'h4444, 3'd4};
        vt[21] = '{F, 16'h3000, F, F, 16'h0021, 16'h0000, F, F, F, 16'h0021, F, 16'hABCD, T, 16'h4444, 3'd0};
        // CPU withdraws its request before being accepted: counter clears, nothing issued
        vt[22] = '{T, 16'h3000, T, F, 16'h0021, 16'h0000, T, F, F, 16'h3000, F, 16'hABCD, F, 16'h4444, 3'd0};
        vt[23] = '{T, 16'h3000, F, F, 16'h0021, 16'h0000, T, F, F, 16'h3000, T, 16'hABCD, F, 16'h4444, 3'd1};
        vt[24] = '{F, 16'h3000, F, F, 16'h0021, 16'h0000, F, F, F, 16'h3000, T, 16'hABCD, F, 16'h4444, 3'd0};

        // Reset held with both requesters active.
        reset     = 1'b0;
        vga_req   = 1'b1;
        vga_addr  = 16'h3000;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0020;
        cpu_wdata = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vga_ready",  0, vga_ready,  1'b0);
        chk("rst_cpu_ready",  0, cpu_ready,  1'b0);
        chk("rst_mem_we",     0, mem_we,     1'b0);
        chk("rst_mem_addr",   0, mem_addr,   16'h0);
        chk("rst_vga_rvalid", 0, vga_rvalid, 1'b0);
        chk("rst_cpu_rvalid", 0, cpu_rvalid, 1'b0);
        chk("rst_starve",     0, starve_cnt, 3'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            vga_req   = vt[i].vreq;
            vga_addr  = vt[i].vaddr;
            cpu_req   = vt[i].creq;
            cpu_we    = vt[i].cwe;
            cpu_addr  = vt[i].caddr;
            cpu_wdata = vt[i].cwdata;
            @(negedge clk);
            chk("vga_ready",  i, vga_ready,  vt[i].e_vrdy);
            chk("cpu_ready",  i, cpu_ready,  vt[i].e_crdy);
            chk("mem_we",     i, mem_we,     vt[i].e_we);
            chk("mem_addr",   i, mem_addr,   vt[i].e_maddr);
            chk("vga_rvalid", i, vga_rvalid, vt[i].e_vrv);
            chk("vga_rdata",  i, vga_rdata,  vt[i].e_vrd);
            chk("cpu_rvalid", i, cpu_rvalid, vt[i].e_crv);
            chk("cpu_rdata",  i, cpu_rdata,  vt[i].e_crd);
            chk("starve_cnt", i, starve_cnt, vt[i].e_st);
            if (vt[i].e_we) chk("mem_wdata", i, mem_wdata, vt[i].cwdata);
            @(posedge clk);
            #1;
        end

        // Reset asserted the cycle after a VGA accept, with the counter part-way up.
        vga_req  = 1'b1;
        vga_addr = 16'h3001;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0020;
        @(negedge clk);
        chk("mr_vga_ready", 0, vga_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("mr_starve", 1, starve_cnt, 3'd1);
        @(posedge clk);
        #1;
        chk("mr_starve", 2, starve_cnt, 3'd2);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_vga_rvalid", 3, vga_rvalid, 1'b0);
        chk("mr_vga_rdata",  3, vga_rdata,  16'h0);
        chk("mr_starve",     3, starve_cnt, 3'd0);
        chk("mr_vga_ready",  3, vga_ready,  1'b0);
        @(posedge clk);
        #1;
        chk("mr_vga_rvalid", 4, vga_rvalid, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_vga_ready", 5, vga_ready,  1'b1);
        chk("mr_cpu_ready", 5, cpu_ready,  1'b0);
        chk("mr_starve",    5, starve_cnt, 3'd0);
        @(posedge clk);
        #1;
        vga_req = 1'b0;
        cpu_req = 1'b0;
        chk("mr_vga_rvalid", 6, vga_rvalid, 1'b1);
        chk("mr_vga_rdata",  6, vga_rdata,  16'h1111);
        chk("mr_starve",     6, starve_cnt, 3'd1);
        @(posedge clk);
        #1;
        chk("mr_vga_rvalid", 7, vga_rvalid, 1'b0);
        chk("mr_starve",     7, starve_cnt, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
